// File: rtl/alu_pkg.sv
// Shared ALU definitions: opsel encodings, requester indices and the
// response-buffer state type used by the shared-ALU arbiter.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTX = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SRX  = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  localparam int unsigned REQ_EXE = 0;
  localparam int unsigned REQ_BR  = 1;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two requesters and the shared-ALU arbiter.
//   slave  : arbiter side (takes requests, returns responses)
//   master : requester side
// Packed fields are {req1, req0}; tags are TAG_W bits per requester.
interface alu_share_arbiter_if #(
  parameter int unsigned TAG_W = 4
) ();

  logic [1:0]         i_req_valid;
  logic [1:0]         o_req_ready;
  logic [5:0]         i_req_opsel;
  logic [1:0]         i_req_sub;
  logic [1:0]         i_req_unsigned;
  logic [1:0]         i_req_arith;
  logic [63:0]        i_req_op1;
  logic [63:0]        i_req_op2;
  logic [2*TAG_W-1:0] i_req_tag;
  logic [1:0]         o_rsp_valid;
  logic [1:0]         i_rsp_ready;
  logic [31:0]        o_rsp_result;
  logic               o_rsp_eq;
  logic               o_rsp_slt;
  logic [TAG_W-1:0]   o_rsp_tag;

  modport slave (
    input  i_req_valid, i_req_opsel, i_req_sub, i_req_unsigned, i_req_arith,
           i_req_op1, i_req_op2, i_req_tag, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_eq, o_rsp_slt,
           o_rsp_tag
  );

  modport master (
    output i_req_valid, i_req_opsel, i_req_sub, i_req_unsigned, i_req_arith,
           i_req_op1, i_req_op2, i_req_tag, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_result, o_rsp_eq, o_rsp_slt,
           o_rsp_tag
  );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU.
//   i_opsel    : operation (see alu_pkg)
//   i_sub      : ADD becomes op1 - op2
//   i_unsigned : less-than compare is unsigned (applies to o_slt always)
//   i_arith    : SRX is arithmetic instead of logical
//   i_op1/i_op2: operands; shifts use i_op2[4:0]
//   o_result, o_eq (op1 == op2), o_slt (op1 < op2)
module alu
  import alu_pkg::*;
(
  input  logic [2:0]  i_opsel,
  input  logic        i_sub,
  input  logic        i_unsigned,
  input  logic        i_arith,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  output logic [31:0] o_result,
  output logic        o_eq,
  output logic        o_slt
);

  logic [4:0] shamt;
  logic       lt;

  assign shamt = i_op2[4:0];
  assign lt    = i_unsigned ? (i_op1 < i_op2) : ($signed(i_op1) < $signed(i_op2));
  assign o_eq  = (i_op1 == i_op2);
  assign o_slt = lt;

  always_comb begin
    o_result = '0;
    unique case (i_opsel)
      ALU_ADD:  o_result = i_sub ? (i_op1 - i_op2) : (i_op1 + i_op2);
      ALU_SLL:  o_result = i_op1 << shamt;
      ALU_SLT,
      ALU_SLTX: o_result = {31'd0, lt};
      ALU_XOR:  o_result = i_op1 ^ i_op2;
      ALU_SRX:  o_result = i_arith ? 32'($signed(i_op1) >>> shamt) : (i_op1 >> shamt);
      ALU_OR:   o_result = i_op1 | i_op2;
      ALU_AND:  o_result = i_op1 & i_op2;
      default:  o_result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin grant.
//   i_en    : a slot is available this cycle
//   i_valid : per-requester request
//   i_last  : index of the most recently granted requester
//   o_gnt   : one-hot grant, or 0
module rr_arb2 (
  input  logic       i_en,
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    if (i_en) begin
      unique case (i_valid)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
        default: o_gnt = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters with round-robin arbitration and a
// one-entry response buffer returned to the owning requester.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : request/response bundle (slave side)
// A response for a request accepted in cycle N is valid in cycle N+1; the
// buffer refills in the same cycle it drains, so throughput is one per cycle.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  alu_share_arbiter_if.slave bus
);

  buf_state_e       state_q, state_d;
  logic             own_q, own_d;
  logic             last_q, last_d;
  logic [31:0]      result_q, result_d;
  logic             eq_q, eq_d;
  logic             slt_q, slt_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic       drain;
  logic       can_accept;
  logic [1:0] gnt;
  logic       accept;
  logic       gsel;

  logic [2:0]       mux_opsel;
  logic             mux_sub, mux_unsigned, mux_arith;
  logic [31:0]      mux_op1, mux_op2;
  logic [TAG_W-1:0] mux_tag;
  logic [31:0]      alu_result;
  logic             alu_eq, alu_slt;

  assign drain      = (state_q == BUF_FULL) && bus.i_rsp_ready[own_q];
  assign can_accept = (state_q == BUF_EMPTY) || drain;

  rr_arb2 u_arb (
    .i_en    (can_accept),
    .i_valid (bus.i_req_valid),
    .i_last  (last_q),
    .o_gnt   (gnt)
  );

  // A grant is only ever issued to a valid requester, so grant == handshake.
  assign accept = |gnt;
  assign gsel   = gnt[1];

  assign mux_opsel    = gsel ? bus.i_req_opsel[5:3] : bus.i_req_opsel[2:0];
  assign mux_sub      = bus.i_req_sub[gsel];
  assign mux_unsigned = bus.i_req_unsigned[gsel];
  assign mux_arith    = bus.i_req_arith[gsel];
  assign mux_op1      = gsel ? bus.i_req_op1[63:32] : bus.i_req_op1[31:0];
  assign mux_op2      = gsel ? bus.i_req_op2[63:32] : bus.i_req_op2[31:0];
  assign mux_tag      = gsel ? bus.i_req_tag[2*TAG_W-1:TAG_W] : bus.i_req_tag[TAG_W-1:0];

  alu u_alu (
    .i_opsel    (mux_opsel),
    .i_sub      (mux_sub),
    .i_unsigned (mux_unsigned),
    .i_arith    (mux_arith),
    .i_op1      (mux_op1),
    .i_op2      (mux_op2),
    .o_result   (alu_result),
    .o_eq       (alu_eq),
    .o_slt      (alu_slt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= BUF_EMPTY;
      own_q    <= 1'b0;
      last_q   <= 1'b1;
      result_q <= '0;
      eq_q     <= 1'b0;
      slt_q    <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      own_q    <= own_d;
      last_q   <= last_d;
      result_q <= result_d;
      eq_q     <= eq_d;
      slt_q    <= slt_d;
      tag_q    <= tag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    last_d   = last_q;
    result_d = result_q;
    eq_d     = eq_q;
    slt_d    = slt_q;
    tag_d    = tag_q;
    if (accept) begin
      state_d  = BUF_FULL;
      own_d    = gsel;
      last_d   = gsel;
      result_d = alu_result;
      eq_d     = alu_eq;
      slt_d    = alu_slt;
      tag_d    = mux_tag;
    end else if (drain) begin
      state_d = BUF_EMPTY;
    end
  end

  always_comb begin
    bus.o_req_ready  = gnt;
    bus.o_rsp_valid  = '0;
    if (state_q == BUF_FULL) begin
      bus.o_rsp_valid = own_q ? 2'b10 : 2'b01;
    end
    bus.o_rsp_result = result_q;
    bus.o_rsp_eq     = eq_q;
    bus.o_rsp_slt    = slt_q;
    bus.o_rsp_tag    = tag_q;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational `alu` instance between two requesters, e.g. port 0 = execute stage and port 1 = branch-compare / multi-cycle helper.
- Arbitrates round-robin and captures the ALU outputs into a one-entry response register.
- Returns the response, with a tag, to the owning requester over a valid/ready handshake.
- Sits between the decode/issue logic and the ALU in the hart datapath.

Parameters:
- TAG_W, 4, width of the opaque requester tag echoed with each response.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  2  per-requester request valid; bit k = requester k.
- o_req_ready  out  2  per-requester accept; at most one bit high.
- i_req_opsel  in  6  {req1[2:0], req0[2:0]}; ALU opsel encoding.
- i_req_sub  in  2  per-requester subtract select.
- i_req_unsigned  in  2  per-requester unsigned-compare select.
- i_req_arith  in  2  per-requester arithmetic-shift select.
- i_req_op1  in  64  {req1, req0} first operands, 32 bits each.
- i_req_op2  in  64  {req1, req0} second operands, 32 bits each.
- i_req_tag  in  2*TAG_W  {req1, req0} tags.
- o_rsp_valid  out  2  one-hot owner of the buffered response; 0 when the buffer is empty.
- i_rsp_ready  in  2  per-requester response accept.
- o_rsp_result  out  32  buffered ALU result.
- o_rsp_eq  out  1  buffered equality flag.
- o_rsp_slt  out  1  buffered less-than flag.
- o_rsp_tag  out  TAG_W  tag of the buffered request.

Behaviour:
- State: the response buffer is either EMPTY or FULL, plus an owner index `own` and a round-robin pointer `last`, the index of the last granted requester.
- Reset (async, i_rst_n=0):
  - state=EMPTY, o_rsp_valid=2'b00, result/eq/slt/tag registers=0, own=0.
  - last=1, so requester 0 wins the first contention.
  - All outputs settle immediately, without waiting for a clock edge.
- Drain: `drain = FULL && i_rsp_ready[own]`.
- Slot free: `can_accept = EMPTY || drain`. A drain and a new accept in the same cycle is a full-throughput refill.
- Grant (combinational, only when can_accept):
  - One valid → that requester wins.
  - Both valid → requester `!last` wins.
  - None valid → no grant.
- o_req_ready = one-hot grant, else 2'b00. o_req_ready may depend on i_req_valid and i_rsp_ready. Requesters must not make valid depend on ready.
- Handshake on requester k: `i_req_valid[k] && o_req_ready[k]`. At the next edge:
  - the ALU outputs for requester k's operands/controls and its tag are registered;
  - own=k, last=k, state=FULL.
- Latency: a request accepted in cycle N is presented as o_rsp_valid[k]=1 in cycle N+1.
- Drain with no new grant → state=EMPTY and o_rsp_valid=0 next cycle. Result/flag/tag registers hold their old values; these are don't-care while valid is 0.
- Backpressure: while FULL and !i_rsp_ready[own]:
  - o_req_ready=0;
  - response registers and o_rsp_valid are held bit-stable.
- i_rsp_ready of the non-owner is ignored.
- Requesters must hold their payload stable while valid and not ready. The arbiter never retracts a grant within a cycle.
- `last` changes only on a completed request handshake. Idle cycles and stalls do not move it.
- Starvation bound: with both requesters continuously valid and the response always accepted, grants strictly alternate.
- ALU semantics are those of the shared `alu` unchanged:
  - 32-bit wrap-around add/sub;
  - shift amount = op2[4:0];
  - opsel 010 and 011 are both set-less-than;
  - o_rsp_slt honours i_req_unsigned for every opsel;
  - eq is a plain 32-bit equality.
- Reset mid-operation: an in-flight buffered response is discarded, with no response and no error flag. Requesters must reissue.

Decomposition:
- Shared package `alu_pkg`:
  - opsel localparams ALU_ADD=3'b000, ALU_SLL=3'b001, ALU_SLT=3'b010, ALU_SLTX=3'b011, ALU_XOR=3'b100, ALU_SRX=3'b101, ALU_OR=3'b110, ALU_AND=3'b111;
  - requester index constants REQ_EXE=0, REQ_BR=1.
- Natural sub-module: `rr_arb2`, a combinational 2-way round-robin grant from {valid, last}.
- The existing `alu` is instantiated once, unmodified, fed by a 2:1 operand/control mux driven by the grant.

Test Plan:
1. Reset; req0 {ADD, op1=5, op2=3, tag=4'hA}; rsp_ready=2'b11 → o_req_ready=2'b01 same cycle; next cycle o_rsp_valid=2'b01, result=8, eq=0, slt=0, tag=4'hA.
2. Both valid every cycle; req0 XOR 0xFF^0x0F, req1 AND 0xF0&0x3C; rsp_ready=11 → grants 0,1,0,1…; one response per cycle with results 0xF0 and 0x30.
3. Stalls: FULL with owner 0, rsp_ready=0 for 3 cycles → o_req_ready=00 and response bits stable. Then rsp_ready[0]=1 with req1 valid → req1 accepted the same cycle; its response follows next cycle.
4. Arithmetic and compare cases:
   - req1 SUB 0-1 → 0xFFFFFFFF.
   - SLT signed -1 vs 1 → result 1, slt=1.
   - SLT unsigned 0xFFFFFFFF vs 1 → 0.
   - SRA 0x80000000 by op2=36 → 0xF8000000 (shift of 4).
   - eq=1 for 7 vs 7.
5. Only req1 valid right after reset (last=1) → granted immediately, no bubble. Both valid next → req0 wins.
6. i_rst_n low mid-FULL, between clock edges → o_rsp_valid=00 immediately. After release with both valid → req0 granted first.
